// File: rtl/rhd_spi_seq.sv
// RHD-family SPI acquisition sequencer: sweeps CONVERT/ROM-read commands, captures MISO lines
// with per-line delay, and streams one word per frame. Define RHD_DDR_EN for dual-edge capture.
module rhd_spi_seq #(
    parameter int NUM_MOSI    = 2,
    parameter int NUM_MISO    = 8,
    parameter int DIV         = 4,
    parameter int NUM_SLOTS   = 35,
    parameter int DLY_W       = 4,
    parameter int CS_HIGH_CYC = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cfg_run,
    input  logic                      cfg_loopback,
    input  logic [NUM_MISO*DLY_W-1:0] cfg_delay,
    input  logic [15:0]               cfg_pkt_len,
    input  logic [NUM_MISO-1:0]       miso,
    output logic                      cs,
    output logic                      sclk,
    output logic [NUM_MOSI-1:0]       mosi,
`ifdef RHD_DDR_EN
    output logic [32*NUM_MISO-1:0]    m_tdata,
`else
    output logic [16*NUM_MISO-1:0]    m_tdata,
`endif
    output logic [6:0]                m_tuser,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic                      busy,
    output logic                      overflow,
    input  logic                      ovf_clr
);
`ifdef RHD_DDR_EN
    localparam int EDGES = 2;
`else
    localparam int EDGES = 1;
`endif
    localparam int          LANE_W     = 16*EDGES;
    localparam int unsigned DEPTH      = 2**DLY_W;
    localparam int          PH_W       = $clog2(DIV);
    localparam int          HI_W       = $clog2(CS_HIGH_CYC);
    localparam int          CONV_SLOTS = NUM_SLOTS-3;

    if (CS_HIGH_CYC < 2**DLY_W) begin : g_chk_cs
        $error("CS_HIGH_CYC must be >= 2**DLY_W");
    end
    if (DIV < 4 || (DIV % 2) != 0) begin : g_chk_div
        $error("DIV must be even and >= 4");
    end
    if (NUM_SLOTS < 4 || NUM_SLOTS > 67) begin : g_chk_slots
        $error("NUM_SLOTS must be in 4..67");
    end

    typedef enum logic [1:0] {IDLE, CS_LOW, CS_HIGH} state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [3:0]      bit_q, bit_d;
    logic [HI_W-1:0] hi_q, hi_d;
    logic [6:0]      slot_q, slot_d;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        hi_d    = hi_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                if (cfg_run) begin
                    state_d = CS_LOW;
                    ph_d    = '0;
                    bit_d   = '0;
                    slot_d  = '0;
                end
            end
            CS_LOW: begin
                if (ph_q == PH_W'(DIV-1)) begin
                    ph_d  = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        state_d = CS_HIGH;
                        hi_d    = '0;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            CS_HIGH: begin
                hi_d = hi_q + HI_W'(1);
                if (hi_q == HI_W'(CS_HIGH_CYC-1)) begin
                    ph_d  = '0;
                    bit_d = '0;
                    if (!cfg_run && slot_q == 7'(NUM_SLOTS-1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = CS_LOW;
                        slot_d  = (slot_q == 7'(NUM_SLOTS-1)) ? '0 : slot_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [15:0] cmd;
    always_comb begin
        if (slot_q < 7'(CONV_SLOTS)) cmd = {2'b00, slot_q[5:0], 8'h00};
        else                         cmd = {2'b11, 6'(7'd40 + slot_q - 7'(CONV_SLOTS)), 8'h00};
    end

    logic mosi_bit;
    assign mosi_bit = (state_q == CS_LOW) ? cmd[~bit_q] : 1'b0;
    assign mosi     = {NUM_MOSI{mosi_bit}};
    assign cs       = (state_q != CS_LOW);
    assign sclk     = (state_q == CS_LOW) && (ph_q >= PH_W'(DIV/2));
    assign busy     = (state_q != IDLE);

    logic [EDGES-1:0] stb_now;
    logic             last_now;
    assign stb_now[0] = (state_q == CS_LOW) && (ph_q == PH_W'(DIV/2));
`ifdef RHD_DDR_EN
    assign stb_now[1] = (state_q == CS_LOW) && (ph_q == PH_W'(DIV-1));
`endif
    assign last_now = stb_now[EDGES-1] && (bit_q == 4'd15);

    // Tap d of the strobe pipeline is the nominal strobe delayed by d cycles; tap 0 is live.
    logic [EDGES-1:0] stb_q [DEPTH-1];
    logic [EDGES-1:0] taps  [DEPTH];
    always_comb begin
        taps[0] = stb_now;
        for (int unsigned k = 1; k < DEPTH; k++) taps[k] = stb_q[k-1];
    end

    logic [DEPTH-2:0] done_q;
    logic [DEPTH-1:0] done_sh;
    logic             word_done;
    assign done_sh   = {done_q, last_now};
    assign word_done = done_q[DEPTH-2];

    logic [NUM_MISO-1:0] rx_bit;
    logic [15:0]         sh_q [NUM_MISO][EDGES];
    logic [15:0]         sh_d [NUM_MISO][EDGES];
    always_comb begin
        for (int unsigned i = 0; i < NUM_MISO; i++) begin
            rx_bit[i] = cfg_loopback ? mosi[i % NUM_MOSI] : miso[i];
            for (int unsigned e = 0; e < EDGES; e++) begin
                sh_d[i][e] = sh_q[i][e];
                if (taps[cfg_delay[i*DLY_W +: DLY_W]][e]) sh_d[i][e] = {sh_q[i][e][14:0], rx_bit[i]};
            end
        end
    end

    // Load from next-state shift data so a bit captured on the completion cycle is included.
    logic [LANE_W*NUM_MISO-1:0] word;
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NUM_MISO; i++)
            for (int unsigned e = 0; e < EDGES; e++)
                word[LANE_W*i + 16*(EDGES-1-e) +: 16] = sh_d[i][e];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            hi_q    <= '0;
            slot_q  <= '0;
            done_q  <= '0;
            for (int unsigned k = 0; k < DEPTH-1; k++) stb_q[k] <= '0;
            for (int unsigned i = 0; i < NUM_MISO; i++)
                for (int unsigned e = 0; e < EDGES; e++) sh_q[i][e] <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            hi_q    <= hi_d;
            slot_q  <= slot_d;
            done_q  <= done_sh[DEPTH-2:0];
            stb_q[0] <= stb_now;
            for (int unsigned k = 1; k < DEPTH-1; k++) stb_q[k] <= stb_q[k-1];
            sh_q <= sh_d;
        end
    end

    logic [LANE_W*NUM_MISO-1:0] tdata_q;
    logic [6:0]                 tuser_q;
    logic                       tvalid_q, tlast_q, ovf_q;
    logic [15:0]                pkt_q, pkt_last;
    logic                       load;

    assign pkt_last = (cfg_pkt_len == 16'd0) ? 16'd0 : cfg_pkt_len - 16'd1;
    assign load     = word_done && (!tvalid_q || m_tready);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tdata_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
            pkt_q    <= '0;
        end else begin
            if (load) begin
                tdata_q  <= word;
                tuser_q  <= slot_q;
                tvalid_q <= 1'b1;
                tlast_q  <= (pkt_q >= pkt_last);
                pkt_q    <= (pkt_q >= pkt_last) ? '0 : pkt_q + 16'd1;
            end else if (m_tready) begin
                tvalid_q <= 1'b0;
            end
            if (state_q != IDLE && state_d == IDLE) pkt_q <= '0;
            if (word_done && !load) ovf_q <= 1'b1;
            else if (ovf_clr)       ovf_q <= 1'b0;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tuser  = tuser_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign overflow = ovf_q;
endmodule
